// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage and the data-memory controller.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_type;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;

  // Requester side (pipeline MEM stage)
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_type,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  // Memory controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_type,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request, programmable latency,
// byte/half/word typed loads and stores, misalignment flagged as an error.
module dmem_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int LAT       = 2,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_ctrl_if.slave  bus
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] T_WORD   = 3'd0;
  localparam logic [2:0] T_HALF_S = 3'd1;
  localparam logic [2:0] T_HALF_U = 3'd2;
  localparam logic [2:0] T_BYTE_S = 3'd3;
  localparam logic [2:0] T_BYTE_U = 3'd4;

  // Counter preload: BUSY lasts LAT-1 cycles so resp_valid lands LAT cycles after the request cycle.
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  // Power-up content of the array; reset never touches it.
  localparam logic [31:0] FILL = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

  // Misaligned address or unknown type code.
  function automatic logic access_err(input logic [2:0] t, input logic [1:0] lo);
    logic e;
    case (t)
      T_WORD:             e = (lo != 2'b00);
      T_HALF_S, T_HALF_U: e = lo[0];
      T_BYTE_S, T_BYTE_U: e = 1'b0;
      default:            e = 1'b1;
    endcase
    return e;
  endfunction

  // Select the addressed lane(s) and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] t,
                                               input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (t)
      T_WORD:   r = w;
      T_HALF_S: r = {{16{h[15]}}, h};
      T_HALF_U: r = {16'h0000, h};
      T_BYTE_S: r = {{24{b[7]}}, b};
      T_BYTE_U: r = {24'h00_0000, b};
      default:  r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Byte lanes touched by a store.
  function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] lo);
    logic [3:0] be;
    case (t)
      T_WORD:             be = 4'b1111;
      T_HALF_S, T_HALF_U: be = lo[1] ? 4'b1100 : 4'b0011;
      T_BYTE_S, T_BYTE_U: be = 4'b0001 << lo;
      default:            be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data replicated across every lane it could land on.
  function automatic logic [31:0] store_lanes(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    case (t)
      T_WORD:             r = d;
      T_HALF_S, T_HALF_U: r = {2{d[15:0]}};
      T_BYTE_S, T_BYTE_U: r = {4{d[7:0]}};
      default:            r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic [31:0] mem [DEPTH] = '{default: FILL};

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_type;
  logic              ready_reg;
  logic              valid_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;
  logic              stall_c;

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [2:0]        acc_type;
  logic              acc_err;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       rd_word;
  logic [3:0]        wr_be;
  logic [31:0]       wr_lanes;

  assign accept     = (state == S_IDLE) && bus.req_valid;
  assign enter_resp = (next_state == S_RESP);

  // With LAT==1 the access happens on the accept edge itself, so use the live request.
  assign acc_we    = (state == S_IDLE) ? bus.req_we    : lat_we;
  assign acc_addr  = (state == S_IDLE) ? bus.req_addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? bus.req_wdata : lat_wdata;
  assign acc_type  = (state == S_IDLE) ? bus.req_type  : lat_type;

  assign acc_err  = access_err(acc_type, acc_addr[1:0]);
  assign widx     = acc_addr[ADDR_W-1:2];
  assign rd_word  = mem[widx];
  assign wr_be    = byte_en(acc_type, acc_addr[1:0]);
  assign wr_lanes = store_lanes(acc_type, acc_wdata);

  // Next-state and latency-counter logic.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (LAT == 1) ? S_RESP : S_BUSY;
          cnt_next   = CNT_LOAD;
        end else begin
          next_state = S_IDLE;
          cnt_next   = cnt;
        end
      end
      S_BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          next_state = S_RESP;
        end else begin
          next_state = S_BUSY;
        end
      end
      S_RESP: begin
        next_state = S_IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        next_state = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Stall follows req_valid in IDLE so MEM holds in the very cycle it presents a request.
  always_comb begin
    stall_c = 1'b0;
    case (state)
      S_IDLE:  stall_c = bus.req_valid;
      S_BUSY:  stall_c = 1'b1;
      S_RESP:  stall_c = 1'b0;
      default: stall_c = 1'b0;
    endcase
  end

  // FSM, request capture and registered response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0000_0000;
      lat_type  <= 3'd0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      rdata_reg <= 32'h0000_0000;
      err_reg   <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      ready_reg <= (next_state == S_IDLE);
      valid_reg <= enter_resp;
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_type  <= bus.req_type;
      end
      if (enter_resp) begin
        err_reg   <= acc_err;
        rdata_reg <= (acc_err || acc_we) ? 32'h0000_0000
                                         : load_extract(rd_word, acc_type, acc_addr[1:0]);
      end
    end
  end

  // Byte-enabled commit on entry to RESP; reset low blocks any pending store.
  always_ff @(posedge clk) begin
    if (rstn && enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[widx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = ready_reg;
  assign bus.resp_valid = valid_reg;
  assign bus.resp_rdata = rdata_reg;
  assign bus.resp_err   = err_reg;
  assign bus.stall      = stall_c;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed plan plus random traffic
// against a word-array reference model, and a latency sweep at LAT=1/7.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(12)) b0 ();
  dmem_ctrl_if #(.ADDR_W(12)) b1 ();
  dmem_ctrl_if #(.ADDR_W(12)) b2 ();

  dmem_ctrl #(.ADDR_W(12), .LAT(2), .INIT_ZERO(1)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
  dmem_ctrl #(.ADDR_W(12), .LAT(1), .INIT_ZERO(1)) u1 (.clk(clk), .rstn(rstn), .bus(b1));
  dmem_ctrl #(.ADDR_W(12), .LAT(7), .INIT_ZERO(1)) u2 (.clk(clk), .rstn(rstn), .bus(b2));

  // Reference model: plain word array of the storage behind u0.
  logic [31:0] model [1024];

  // Sweep bookkeeping, index 0 = LAT1 instance, 1 = LAT7 instance.
  int   sw_acc_cyc [2];
  int   sw_accepts [2];
  int   sw_resps   [2];
  logic sw_outst   [2];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [2:0] t, input logic [11:0] a);
    if (t > 3'd4) return 1'b1;
    if (t == 3'd0) return (a % 12'd4) != 12'd0;
    if (t == 3'd1 || t == 3'd2) return (a % 12'd2) != 12'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t,
                                           input logic [11:0] a);
    logic [31:0] v;
    v = w >> (8 * int'(a % 12'd4));
    case (t)
      3'd1:    return 32'($signed(v[15:0]));
      3'd2:    return v & 32'h0000_FFFF;
      3'd3:    return 32'($signed(v[7:0]));
      3'd4:    return v & 32'h0000_00FF;
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] t, input logic [11:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    int          idx;
    idx  = int'(a / 12'd4);
    sh   = 8 * int'(a % 12'd4);
    mask = (t == 3'd0) ? 32'hFFFF_FFFF : ((t <= 3'd2) ? 32'h0000_FFFF : 32'h0000_00FF);
    model[idx] = (model[idx] & ~(mask << sh)) | ((d & mask) << sh);
  endtask

  // One request on u0, full handshake and timing checks, result checked against the model.
  task automatic do_req(input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic [2:0] t, output logic [31:0] rd, output logic er);
    int          n;
    logic        got;
    logic        exp_err;
    logic [31:0] exp_rd;
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_we    = we;
    b0.req_addr  = a;
    b0.req_wdata = d;
    b0.req_type  = t;
    #1;
    check1("stall_on_request", b0.stall, 1'b1);
    check1("ready_in_idle", b0.req_ready, 1'b1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      b0.req_valid = 1'b0;
      if (b0.resp_valid) begin
        got = 1'b1;
      end else begin
        check1("stall_busy", b0.stall, 1'b1);
        check1("ready_busy", b0.req_ready, 1'b0);
      end
    end
    check32("latency", 32'(n), 32'd2);
    check1("stall_resp", b0.stall, 1'b0);
    check1("ready_resp", b0.req_ready, 1'b0);
    rd      = b0.resp_rdata;
    er      = b0.resp_err;
    exp_err = ref_err(t, a);
    exp_rd  = (exp_err || we) ? 32'h0 : ref_load(model[int'(a / 12'd4)], t, a);
    check1("resp_err", er, exp_err);
    check32("resp_rdata", rd, exp_rd);
    if (we && !exp_err) ref_store(t, a, d);
    @(negedge clk);
    check1("resp_one_pulse", b0.resp_valid, 1'b0);
    check1("ready_after", b0.req_ready, 1'b1);
  endtask

  task automatic sweep_step(input int k, input int c, input logic rdy, input logic rv,
                            input int lat);
    if (sw_outst[k]) check1("sweep_ready_low", rdy, 1'b0);
    if (rv) begin
      check1("sweep_resp_has_accept", sw_outst[k], 1'b1);
      check32("sweep_latency", 32'(c - sw_acc_cyc[k]), 32'(lat));
      sw_resps[k]++;
      sw_outst[k] = 1'b0;
    end else if (!sw_outst[k] && rdy) begin
      if (sw_accepts[k] > 0) check32("sweep_spacing", 32'(c - sw_acc_cyc[k]), 32'(lat + 1));
      sw_accepts[k]++;
      sw_acc_cyc[k] = c;
      sw_outst[k]   = 1'b1;
    end
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    for (int k = 0; k < 2; k++) begin
      sw_acc_cyc[k] = 0;
      sw_accepts[k] = 0;
      sw_resps[k]   = 0;
      sw_outst[k]   = 1'b0;
    end
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 12'h0; b0.req_wdata = 32'h0; b0.req_type = 3'd0;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 12'h0; b1.req_wdata = 32'h0; b1.req_type = 3'd0;
    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = 12'h0; b2.req_wdata = 32'h0; b2.req_type = 3'd0;
    rstn = 1'b0;
    #12;
    check1("rst_ready", b0.req_ready, 1'b1);
    check1("rst_valid", b0.resp_valid, 1'b0);
    check32("rst_rdata", b0.resp_rdata, 32'h0);
    check1("rst_err", b0.resp_err, 1'b0);
    check1("rst_stall", b0.stall, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Word store then load.
    do_req(1'b1, 12'h010, 32'hDEAD_BEEF, 3'd0, rd, er);
    do_req(1'b0, 12'h010, 32'h0, 3'd0, rd, er);
    check32("word_load", rd, 32'hDEAD_BEEF);

    // Sub-word stores and sign/zero extension.
    do_req(1'b1, 12'h010, 32'h1122_3344, 3'd0, rd, er);
    do_req(1'b1, 12'h013, 32'h0000_005A, 3'd3, rd, er);
    do_req(1'b0, 12'h010, 32'h0, 3'd0, rd, er);
    check32("byte_merge", rd, 32'h5A22_3344);
    do_req(1'b0, 12'h013, 32'h0, 3'd3, rd, er);
    check32("byte_s_pos", rd, 32'h0000_005A);
    do_req(1'b1, 12'h012, 32'h0000_0080, 3'd4, rd, er);
    do_req(1'b0, 12'h012, 32'h0, 3'd3, rd, er);
    check32("byte_s_neg", rd, 32'hFFFF_FF80);
    do_req(1'b0, 12'h012, 32'h0, 3'd4, rd, er);
    check32("byte_u", rd, 32'h0000_0080);

    // Half access.
    do_req(1'b1, 12'h020, 32'h0, 3'd0, rd, er);
    do_req(1'b1, 12'h022, 32'h0000_BEEF, 3'd1, rd, er);
    do_req(1'b0, 12'h020, 32'h0, 3'd0, rd, er);
    check32("half_merge", rd, 32'hBEEF_0000);
    do_req(1'b0, 12'h022, 32'h0, 3'd1, rd, er);
    check32("half_s", rd, 32'hFFFF_BEEF);
    do_req(1'b0, 12'h022, 32'h0, 3'd2, rd, er);
    check32("half_u", rd, 32'h0000_BEEF);

    // Misalignment and illegal type.
    do_req(1'b0, 12'h011, 32'h0, 3'd0, rd, er);
    check1("mis_word_err", er, 1'b1);
    do_req(1'b1, 12'h013, 32'h0000_FFFF, 3'd1, rd, er);
    check1("mis_half_err", er, 1'b1);
    check32("mis_half_rdata", rd, 32'h0);
    do_req(1'b1, 12'h010, 32'h1234_5678, 3'd7, rd, er);
    check1("bad_type_err", er, 1'b1);
    do_req(1'b0, 12'h010, 32'h0, 3'd0, rd, er);
    check32("mis_unchanged", rd, 32'h5A80_3344);

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)), $urandom,
             3'($urandom_range(0, 7)), rd, er);
    end

    // Reset asserted while a store sits in BUSY.
    do_req(1'b1, 12'h040, 32'h0, 3'd0, rd, er);
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = 12'h040;
    b0.req_wdata = 32'hCAFE_BABE; b0.req_type = 3'd0;
    @(posedge clk);
    #2;
    b0.req_valid = 1'b0;
    check1("pre_rst_busy", b0.req_ready, 1'b0);
    rstn = 1'b0;
    #1;
    check1("mid_rst_ready", b0.req_ready, 1'b1);
    check1("mid_rst_valid", b0.resp_valid, 1'b0);
    check32("mid_rst_rdata", b0.resp_rdata, 32'h0);
    check1("mid_rst_err", b0.resp_err, 1'b0);
    check1("mid_rst_stall", b0.stall, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    do_req(1'b0, 12'h040, 32'h0, 3'd0, rd, er);
    check32("rst_store_dropped", rd, 32'h0);

    // Latency sweep with req_valid held high on the LAT=1 and LAT=7 instances.
    @(negedge clk);
    b1.req_valid = 1'b1;
    b2.req_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      #1;
      sweep_step(0, c, b1.req_ready, b1.resp_valid, 1);
      sweep_step(1, c, b2.req_ready, b2.resp_valid, 7);
      @(negedge clk);
    end
    b1.req_valid = 1'b0;
    b2.req_valid = 1'b0;
    check32("sweep1_count", 32'(sw_resps[0]), 32'(sw_accepts[0] - int'(sw_outst[0])));
    check32("sweep7_count", 32'(sw_resps[1]), 32'(sw_accepts[1] - int'(sw_outst[1])));
    check1("sweep1_active", sw_accepts[0] > 20, 1'b1);
    check1("sweep7_active", sw_accepts[1] > 5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
